// File: rtl/adrv9001_rx_packetizer.sv
// ADRV9001 receive-channel packetizer: buffers the free-running I/Q stream
// and re-emits it as an AXI-stream with programmable-length tlast framing.
module adrv9001_rx_packetizer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  axis_aclk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  overflow,
    output logic [31:0]           overflow_cnt,
    output logic                  busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_mem_user;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic [LEN_WIDTH-1:0]  r_len_m1;
    logic [LEN_WIDTH-1:0]  r_in_cnt;
    logic [LEN_WIDTH-1:0]  r_out_cnt;
    logic                  r_pend_user;
    logic                  r_overflow;
    logic [31:0]           r_overflow_cnt;

    logic                  w_start;
    logic                  w_capture;
    logic                  w_wr_req;
    logic                  w_full;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_drop;
    logic                  w_in_wrap;
    logic [LEN_WIDTH-1:0]  w_in_nxt;

    assign w_start   = (r_state == IDLE) && enable;
    assign w_capture = (r_state == RUN) || (r_state == FINISH);
    assign w_wr_req  = w_capture && s_axis_tvalid;
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_rd      = m_axis_tvalid && m_axis_tready;
    assign w_wr      = w_wr_req && (!w_full || w_rd);
    assign w_drop    = w_wr_req && !w_wr;
    assign w_in_wrap = w_wr && (r_in_cnt == r_len_m1);

    // Stop decisions use the post-write count so a packet is never cut short
    always_comb begin
        w_in_nxt = r_in_cnt;
        if (w_in_wrap) begin
            w_in_nxt = '0;
        end else if (w_wr) begin
            w_in_nxt = r_in_cnt + LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    w_state_nxt = (w_in_nxt == '0) ? DRAIN : FINISH;
                end
            end
            FINISH: begin
                if (w_in_nxt == '0) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_count == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
    end

    always_ff @(posedge axis_aclk) begin
        if (w_wr) begin
            r_mem_data[r_wr_ptr] <= s_axis_tdata;
            r_mem_user[r_wr_ptr] <= r_pend_user;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (rst) begin
            r_len_m1  <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else if (w_start) begin
            r_len_m1  <= (pkt_len == '0) ? '0 : pkt_len - LEN_WIDTH'(1);
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            r_in_cnt <= w_in_nxt;
            if (w_rd) begin
                if (r_out_cnt == r_len_m1) begin
                    r_out_cnt <= '0;
                end else begin
                    r_out_cnt <= r_out_cnt + LEN_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (rst) begin
            r_pend_user    <= 1'b0;
            r_overflow     <= 1'b0;
            r_overflow_cnt <= '0;
        end else if (w_start) begin
            r_pend_user    <= 1'b0;
            r_overflow     <= 1'b0;
            r_overflow_cnt <= '0;
        end else if (w_drop) begin
            r_pend_user <= 1'b1;
            r_overflow  <= 1'b1;
            if (r_overflow_cnt != 32'hFFFF_FFFF) begin
                r_overflow_cnt <= r_overflow_cnt + 32'd1;
            end
        end else if (w_wr) begin
            r_pend_user <= 1'b0;
        end
    end

    assign m_axis_tvalid = (r_count != '0);
    assign m_axis_tdata  = m_axis_tvalid ? r_mem_data[r_rd_ptr] : '0;
    assign m_axis_tuser  = m_axis_tvalid && r_mem_user[r_rd_ptr];
    assign m_axis_tlast  = m_axis_tvalid && (r_out_cnt == r_len_m1);
    assign overflow      = r_overflow;
    assign overflow_cnt  = r_overflow_cnt;

endmodule
